// File: rtl/reindeer_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory read
// in flight, and hands each fetched word plus its address to decode with a one-cycle pulse.
module reindeer_fetch_stage #(
    parameter int                  XLEN     = 32,
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sync_reset,
    input  logic                fetch_init,
    input  logic [PC_WIDTH-1:0] start_addr,
    input  logic                fetch_next,
    input  logic                jump_request,
    input  logic [PC_WIDTH-1:0] jump_addr,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic                mem_read_en,
    input  logic                mem_read_ack,
    input  logic [XLEN-1:0]     mem_data,
    output logic                enable_out,
    output logic [XLEN-1:0]     IR_out,
    output logic [PC_WIDTH-1:0] PC_out,
    output logic                fetch_busy,
    output logic                exception_misaligned,
    output logic [PC_WIDTH-1:0] exception_addr
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pending_pc;
    logic                discard;

    logic                redirect;
    logic                misaligned;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] issue_pc;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        redirect   = fetch_init | jump_request;
        target     = fetch_init ? start_addr : jump_addr;
        misaligned = redirect && (target[1:0] != 2'b00);
        issue_pc   = redirect ? target : pc + PC_WIDTH'(4);
    end

    // A read being discarded is still in flight even after dropping back to IDLE.
    assign fetch_busy = (state == WAIT) || discard;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            pc                   <= RESET_PC;
            pending_pc           <= RESET_PC;
            discard              <= 1'b0;
            mem_addr             <= RESET_PC;
            mem_read_en          <= 1'b0;
            enable_out           <= 1'b0;
            IR_out               <= '0;
            PC_out               <= '0;
            exception_misaligned <= 1'b0;
            exception_addr       <= '0;
        end else if (sync_reset) begin
            state                <= IDLE;
            pc                   <= RESET_PC;
            pending_pc           <= RESET_PC;
            discard              <= 1'b0;
            mem_addr             <= RESET_PC;
            mem_read_en          <= 1'b0;
            enable_out           <= 1'b0;
            IR_out               <= '0;
            PC_out               <= '0;
            exception_misaligned <= 1'b0;
            exception_addr       <= '0;
        end else begin
            mem_read_en          <= 1'b0;
            enable_out           <= 1'b0;
            exception_misaligned <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (mem_read_ack) discard <= 1'b0;
                    if (misaligned) begin
                        exception_misaligned <= 1'b1;
                        exception_addr       <= target;
                        state                <= IDLE;
                    end else if (redirect && discard && !mem_read_ack) begin
                        // Stale read still out: park the target until its ack drains.
                        pending_pc <= target;
                        state      <= WAIT;
                    end else if (redirect || (fetch_next && state == HOLD)) begin
                        pc          <= issue_pc;
                        mem_addr    <= issue_pc;
                        mem_read_en <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_read_ack) begin
                        discard <= 1'b0;
                        if (misaligned) begin
                            exception_misaligned <= 1'b1;
                            exception_addr       <= target;
                            state                <= IDLE;
                        end else if (redirect) begin
                            pc          <= target;
                            mem_addr    <= target;
                            mem_read_en <= 1'b1;
                        end else if (discard) begin
                            pc          <= pending_pc;
                            mem_addr    <= pending_pc;
                            mem_read_en <= 1'b1;
                        end else begin
                            enable_out <= 1'b1;
                            IR_out     <= mem_data;
                            PC_out     <= mem_addr;
                            state      <= HOLD;
                        end
                    end else if (redirect) begin
                        discard    <= 1'b1;
                        pending_pc <= target;
                        if (misaligned) begin
                            exception_misaligned <= 1'b1;
                            exception_addr       <= target;
                            state                <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
